// File: rtl/test_increment.sv
// Program-counter increment unit: holds, increments, loads an absolute target or adds a
// sign-extended relative offset, and flags any modulo wrap of pc for one cycle.
module test_increment #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned OFF_W      = 8,
  parameter logic [31:0] RESET_ADDR = 32'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              ld,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              rel,
  input  logic [OFF_W-1:0]  rel_off,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_ADDR);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              wrap_q, wrap_d;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W:0]   rel_sum;
  logic [ADDR_W:0]   inc_sum;
  logic              off_neg;

  assign off_neg = rel_off[OFF_W-1];
  assign off_ext = ADDR_W'($signed(rel_off));
  assign rel_sum = {1'b0, pc_q} + {1'b0, off_ext};
  assign inc_sum = {1'b0, pc_q} + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    if (stall) begin
      pc_d = pc_q;
    end else if (ld) begin
      pc_d = ld_addr;
    end else if (rel) begin
      pc_d = rel_sum[ADDR_W-1:0];
      // With a negative offset the add carries out exactly when no borrow occurred.
      wrap_d = off_neg ? ~rel_sum[ADDR_W] : rel_sum[ADDR_W];
    end else if (inc) begin
      pc_d   = inc_sum[ADDR_W-1:0];
      wrap_d = inc_sum[ADDR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= ResetPc;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

  assign pc       = pc_q;
  assign pc_plus1 = inc_sum[ADDR_W-1:0];
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_test_increment.sv
// Directed table-driven bench for test_increment (ADDR_W=10, OFF_W=8, RESET_ADDR=0).
module tb_test_increment;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall;
  logic       ld;
  logic [9:0] ld_addr;
  logic       rel;
  logic [7:0] rel_off;
  logic       inc;
  logic [9:0] pc;
  logic [9:0] pc_plus1;
  logic       wrap;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  test_increment #(
    .ADDR_W    (10),
    .OFF_W     (8),
    .RESET_ADDR(32'd0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall   (stall),
    .ld      (ld),
    .ld_addr (ld_addr),
    .rel     (rel),
    .rel_off (rel_off),
    .inc     (inc),
    .pc      (pc),
    .pc_plus1(pc_plus1),
    .wrap    (wrap)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic       stall;
    logic       ld;
    logic [9:0] ld_addr;
    logic       rel;
    logic [7:0] rel_off;
    logic       inc;
    logic [9:0] exp_pc;
    logic [9:0] exp_plus1;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic r, logic s, logic l, logic [9:0] la,
                              logic rl, logic [7:0] ro, logic i, logic [9:0] epc,
                              logic [9:0] ep1, logic ew);
    vec_t v;
    v.name = name; v.rst_n = r; v.stall = s; v.ld = l; v.ld_addr = la;
    v.rel = rl; v.rel_off = ro; v.inc = i;
    v.exp_pc = epc; v.exp_plus1 = ep1; v.exp_wrap = ew;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(logic r, logic s, logic l, logic [9:0] la, logic rl, logic [7:0] ro,
                       logic i);
    rst_n = r; stall = s; ld = l; ld_addr = la; rel = rl; rel_off = ro; inc = i;
  endtask

  task automatic step_check(string name, logic [9:0] epc, logic [9:0] ep1, logic ew);
    @(posedge clk);
    #1;
    check({name, ".pc"}, 32'(pc), 32'(epc));
    check({name, ".pc_plus1"}, 32'(pc_plus1), 32'(ep1));
    check({name, ".wrap"}, 32'(wrap), 32'(ew));
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 10'h0, 1'b0, 8'h0, 1'b0);

    //             name          rst stl ld  ld_addr rel off    inc pc      pc+1    wrap
    vecs.push_back(mk("reset0",   0, 0, 0, 10'h000, 0, 8'h00, 0, 10'h000, 10'h001, 0));
    vecs.push_back(mk("reset1",   0, 0, 0, 10'h000, 0, 8'h00, 1, 10'h000, 10'h001, 0));
    vecs.push_back(mk("inc1",     1, 0, 0, 10'h000, 0, 8'h00, 1, 10'h001, 10'h002, 0));
    vecs.push_back(mk("inc2",     1, 0, 0, 10'h000, 0, 8'h00, 1, 10'h002, 10'h003, 0));
    vecs.push_back(mk("inc3",     1, 0, 0, 10'h000, 0, 8'h00, 1, 10'h003, 10'h004, 0));
    vecs.push_back(mk("ld3fe",    1, 0, 1, 10'h3FE, 0, 8'h00, 0, 10'h3FE, 10'h3FF, 0));
    vecs.push_back(mk("inc3ff",   1, 0, 0, 10'h000, 0, 8'h00, 1, 10'h3FF, 10'h000, 0));
    vecs.push_back(mk("incwrap",  1, 0, 0, 10'h000, 0, 8'h00, 1, 10'h000, 10'h001, 1));
    vecs.push_back(mk("hold",     1, 0, 0, 10'h000, 0, 8'h00, 0, 10'h000, 10'h001, 0));
    vecs.push_back(mk("ld010",    1, 0, 1, 10'h010, 0, 8'h00, 0, 10'h010, 10'h011, 0));
    vecs.push_back(mk("relm4",    1, 0, 0, 10'h000, 1, 8'hFC, 0, 10'h00C, 10'h00D, 0));
    vecs.push_back(mk("rel7f",    1, 0, 0, 10'h000, 1, 8'h7F, 0, 10'h08B, 10'h08C, 0));
    vecs.push_back(mk("ld002",    1, 0, 1, 10'h002, 0, 8'h00, 0, 10'h002, 10'h003, 0));
    vecs.push_back(mk("relborr",  1, 0, 0, 10'h000, 1, 8'hFC, 0, 10'h3FE, 10'h3FF, 1));
    vecs.push_back(mk("ld3f0",    1, 0, 1, 10'h3F0, 0, 8'h00, 0, 10'h3F0, 10'h3F1, 0));
    vecs.push_back(mk("relcarry", 1, 0, 0, 10'h000, 1, 8'h7F, 0, 10'h06F, 10'h070, 1));
    vecs.push_back(mk("prio_stl", 1, 1, 1, 10'h100, 1, 8'hFC, 1, 10'h06F, 10'h070, 0));
    vecs.push_back(mk("prio_ld",  1, 0, 1, 10'h100, 1, 8'hFC, 1, 10'h100, 10'h101, 0));
    vecs.push_back(mk("prio_rel", 1, 0, 0, 10'h100, 1, 8'hFC, 1, 10'h0FC, 10'h0FD, 0));
    vecs.push_back(mk("prio_inc", 1, 0, 0, 10'h100, 0, 8'hFC, 1, 10'h0FD, 10'h0FE, 0));
    vecs.push_back(mk("ld155",    1, 0, 1, 10'h155, 0, 8'h00, 0, 10'h155, 10'h156, 0));
    vecs.push_back(mk("midrst",   0, 0, 1, 10'h3FF, 0, 8'h00, 0, 10'h000, 10'h001, 0));
    vecs.push_back(mk("postrst",  1, 0, 0, 10'h000, 0, 8'h00, 1, 10'h001, 10'h002, 0));

    foreach (vecs[k]) begin
      drive(vecs[k].rst_n, vecs[k].stall, vecs[k].ld, vecs[k].ld_addr, vecs[k].rel,
            vecs[k].rel_off, vecs[k].inc);
      step_check(vecs[k].name, vecs[k].exp_pc, vecs[k].exp_plus1, vecs[k].exp_wrap);
    end

    // Stall right after a wrap clears wrap and freezes pc over several cycles.
    drive(1'b1, 1'b0, 1'b1, 10'h3FF, 1'b0, 8'h00, 1'b0);
    step_check("sw_ld", 10'h3FF, 10'h000, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b1);
    step_check("sw_wrap", 10'h000, 10'h001, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 10'h000, 1'b1, 8'h05, 1'b1);
    for (int i = 0; i < 4; i++) step_check("sw_stall", 10'h000, 10'h001, 1'b0);

    // Reset clears a pending wrap flag; zero offset never wraps.
    drive(1'b1, 1'b0, 1'b1, 10'h3FF, 1'b0, 8'h00, 1'b0);
    step_check("rw_ld", 10'h3FF, 10'h000, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 8'h01, 1'b0);
    step_check("rw_relwrap", 10'h000, 10'h001, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 8'h01, 1'b1);
    step_check("rw_reset", 10'h000, 10'h001, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 8'h00, 1'b0);
    step_check("rw_rel0", 10'h000, 10'h001, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 8'h80, 1'b0);
    step_check("rw_relm128", 10'h380, 10'h381, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
